// File: rtl/t05_lcd1602_model.sv
// Responder-side model of a 1602 character LCD: decodes the {rs,rw,data} word stream into a 2x16 DDRAM image.
// Build with LCD_MODEL_FRAME_EN defined to pulse frame_done after the last visible char of line 2 is written.
module t05_lcd1602_model #(
   parameter int EXEC_CYCLES = 40,
   parameter int LONG_CYCLES = 1600
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [9:0]   in_word,
   input  logic         in_valid,
   output logic [127:0] row_1,
   output logic [127:0] row_2,
   output logic [6:0]   addr,
   output logic         disp_on,
   output logic         two_line,
   output logic         busy,
   output logic         err,
   output logic         frame_done
);

   localparam int CW = $clog2(LONG_CYCLES + 1);
   localparam logic [127:0] BLANK = {16{8'h20}};

   logic [CW-1:0] cnt, cnt_n;
   logic [127:0]  row_1_n, row_2_n;
   logic [6:0]    addr_n, base;
   logic          id, id_n, cgram_sel, cgram_sel_n;
   logic          disp_on_n, two_line_n;
   logic          rs, rw, accept, drop;
   logic [7:0]    d;

   assign rs     = in_word[9];
   assign rw     = in_word[8];
   assign d      = in_word[7:0];
   assign busy   = (cnt != '0);
   assign accept = in_valid && !busy && !rw;
   assign drop   = in_valid && (busy || rw);
   assign base   = 7'd127 - {addr[3:0], 3'b000};

   // DDRAM counter walks line 1 (0x00-0x27) then line 2 (0x40-0x67) as one ring
   function automatic logic [6:0] step(input logic [6:0] a, input logic inc);
      if (inc)
         return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      else
         return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
   endfunction

`ifdef LCD_MODEL_FRAME_EN
   logic frame_n;
`endif

   always_comb begin
      row_1_n     = row_1;
      row_2_n     = row_2;
      addr_n      = addr;
      id_n        = id;
      cgram_sel_n = cgram_sel;
      disp_on_n   = disp_on;
      two_line_n  = two_line;
      cnt_n       = busy ? cnt - CW'(1) : '0;
`ifdef LCD_MODEL_FRAME_EN
      frame_n     = 1'b0;
`endif
      if (accept) begin
         cnt_n = CW'(EXEC_CYCLES);
         if (!rs) begin
            unique case (1'b1)
               d[7]: begin
                  addr_n      = d[6:0];
                  cgram_sel_n = 1'b0;
               end
               d[7:6] == 2'b01:      cgram_sel_n = 1'b1;
               d[7:5] == 3'b001:     two_line_n = d[3];
               d[7:4] == 4'b0001:    ;
               d[7:3] == 5'b00001:   disp_on_n = d[2];
               d[7:2] == 6'b000001:  id_n = d[1];
               d[7:1] == 7'b0000001: begin
                  addr_n = '0;
                  cnt_n  = CW'(LONG_CYCLES);
               end
               d == 8'h01: begin
                  row_1_n = BLANK;
                  row_2_n = BLANK;
                  addr_n  = '0;
                  id_n    = 1'b1;
                  cnt_n   = CW'(LONG_CYCLES);
               end
               default: ;
            endcase
         end else if (!cgram_sel) begin
            if (addr[6:4] == 3'b000)
               row_1_n[base -: 8] = d;
            else if (addr[6:4] == 3'b100)
               row_2_n[base -: 8] = d;
            addr_n = step(addr, id);
`ifdef LCD_MODEL_FRAME_EN
            frame_n = (addr == 7'h4F);
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_1     <= BLANK;
         row_2     <= BLANK;
         addr      <= '0;
         id        <= 1'b1;
         cgram_sel <= 1'b0;
         disp_on   <= 1'b0;
         two_line  <= 1'b0;
         cnt       <= '0;
         err       <= 1'b0;
      end else begin
         row_1     <= row_1_n;
         row_2     <= row_2_n;
         addr      <= addr_n;
         id        <= id_n;
         cgram_sel <= cgram_sel_n;
         disp_on   <= disp_on_n;
         two_line  <= two_line_n;
         cnt       <= cnt_n;
         err       <= drop;
      end
   end

`ifdef LCD_MODEL_FRAME_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) frame_done <= 1'b0;
      else      frame_done <= frame_n;
   end
`else
   assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_t05_lcd1602_model.sv
// Scoreboard bench for t05_lcd1602_model: expected display snapshots are queued per word and popped after the accepting edge.
module tb_t05_lcd1602_model;

   localparam int EXEC = 40;
   localparam int LONG = 1600;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [9:0]   in_word = '0;
   logic         in_valid = 1'b0;
   logic [127:0] row_1, row_2;
   logic [6:0]   addr;
   logic         disp_on, two_line, busy, err, frame_done;

   t05_lcd1602_model #(.EXEC_CYCLES(EXEC), .LONG_CYCLES(LONG)) dut (
      .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
      .row_1(row_1), .row_2(row_2), .addr(addr), .disp_on(disp_on),
      .two_line(two_line), .busy(busy), .err(err), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [127:0] r1;
      logic [127:0] r2;
      logic [6:0]   a;
      logic         d;
      logic         t;
   } snap_t;

   snap_t sb[$];
   int n_chk = 0, n_fail = 0;
   int err_cnt = 0, frame_cnt = 0;

   always @(posedge clk) begin
      if (err) err_cnt++;
      if (frame_done) frame_cnt++;
   end

   logic [7:0] m1[16], m2[16];
   logic [6:0] m_addr;
   logic       m_id, m_cg, m_disp, m_two;

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m1[i] = 8'h20;
         m2[i] = 8'h20;
      end
      m_addr = '0; m_id = 1'b1; m_cg = 1'b0; m_disp = 1'b0; m_two = 1'b0;
   endfunction

   function automatic void model_apply(input logic [9:0] w);
      logic [7:0] dd;
      dd = w[7:0];
      if (!w[9]) begin
         priority casez (dd)
            8'b1???????: begin m_addr = dd[6:0]; m_cg = 1'b0; end
            8'b01??????: m_cg = 1'b1;
            8'b001?????: m_two = dd[3];
            8'b0001????: ;
            8'b00001???: m_disp = dd[2];
            8'b000001??: m_id = dd[1];
            8'b0000001?: m_addr = '0;
            8'b00000001: begin
               for (int i = 0; i < 16; i++) begin
                  m1[i] = 8'h20;
                  m2[i] = 8'h20;
               end
               m_addr = '0;
               m_id = 1'b1;
            end
            default: ;
         endcase
      end else if (!m_cg) begin
         if (m_addr <= 7'h0F) m1[m_addr[3:0]] = dd;
         else if (m_addr >= 7'h40 && m_addr <= 7'h4F) m2[m_addr[3:0]] = dd;
         if (m_id) begin
            if (m_addr == 7'h27) m_addr = 7'h40;
            else if (m_addr == 7'h67) m_addr = 7'h00;
            else m_addr = m_addr + 7'd1;
         end else begin
            if (m_addr == 7'h00) m_addr = 7'h67;
            else if (m_addr == 7'h40) m_addr = 7'h27;
            else m_addr = m_addr - 7'd1;
         end
      end
   endfunction

   function automatic snap_t snap();
      snap_t s;
      for (int i = 0; i < 16; i++) begin
         s.r1[127-8*i -: 8] = m1[i];
         s.r2[127-8*i -: 8] = m2[i];
      end
      s.a = m_addr; s.d = m_disp; s.t = m_two;
      return s;
   endfunction

   task automatic drive(input logic [9:0] w, input bit drop);
      @(negedge clk);
      in_word = w;
      in_valid = 1'b1;
      if (!drop) model_apply(w);
      sb.push_back(snap());
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      snap_t s;
      rst = 1'b0;
      model_reset();
      sb.push_back(snap());
      idle(2);
      rst = 1'b1;
      idle(1);
      s = sb.pop_front();
      n_chk++;
      if ({row_1, row_2, addr, disp_on, two_line} !== s) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", {row_1, row_2, addr, disp_on, two_line}, s);
      end
      n_chk++;
      if ({busy, err, frame_done} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 000", {busy, err, frame_done});
      end
   endtask

   task automatic test_init();
      logic [9:0] seq[6] = '{10'h038, 10'h008, 10'h001, 10'h006, 10'h002, 10'h00C};
      snap_t s;
      int e0;
      e0 = err_cnt;
      foreach (seq[i]) begin
         drive(seq[i], 1'b0);
         s = sb.pop_front();
         n_chk++;
         if ({row_1, row_2, addr, disp_on, two_line, busy} !== {s, 1'b1}) begin
            n_fail++;
            $display("FAIL init_%0d: got %h want %h", i, {row_1, row_2, addr, disp_on, two_line, busy}, {s, 1'b1});
         end
         idle(LONG + 1);
      end
      n_chk++;
      if ({two_line, disp_on, addr} !== {1'b1, 1'b1, 7'h00} || err_cnt != e0) begin
         n_fail++;
         $display("FAIL init_final: got %b%b %h err %0d want 11 00 err 0", two_line, disp_on, addr, err_cnt - e0);
      end
   endtask

   task automatic test_hi();
      logic [9:0] seq[3] = '{10'h080, 10'h248, 10'h269};
      snap_t s;
      foreach (seq[i]) begin
         drive(seq[i], 1'b0);
         s = sb.pop_front();
         n_chk++;
         if ({row_1, row_2, addr} !== {s.r1, s.r2, s.a}) begin
            n_fail++;
            $display("FAIL hi_%0d: got %h %h %h want %h %h %h", i, row_1, row_2, addr, s.r1, s.r2, s.a);
         end
         idle(EXEC + 1);
      end
      n_chk++;
      if ({row_1[127:112], addr} !== {16'h4869, 7'h02}) begin
         n_fail++;
         $display("FAIL hi_final: got %h %h want 4869 02", row_1[127:112], addr);
      end
   endtask

   task automatic test_line2();
      logic [127:0] want;
      snap_t s;
      int f0, fexp;
      want = "ABCDEFGHIJKLMNOP";
`ifdef LCD_MODEL_FRAME_EN
      fexp = 1;
`else
      fexp = 0;
`endif
      f0 = frame_cnt;
      for (int i = 0; i <= 16; i++) begin
         drive((i == 0) ? 10'h0C0 : 10'(10'h240 + i), 1'b0);
         s = sb.pop_front();
         n_chk++;
         if ({row_1, row_2, addr} !== {s.r1, s.r2, s.a}) begin
            n_fail++;
            $display("FAIL line2_%0d: got %h %h want %h %h", i, row_2, addr, s.r2, s.a);
         end
         idle(EXEC + 1);
      end
      n_chk++;
      if ({row_2, addr} !== {want, 7'h50}) begin
         n_fail++;
         $display("FAIL line2_final: got %h %h want %h 50", row_2, addr, want);
      end
      n_chk++;
      if (frame_cnt - f0 != fexp) begin
         n_fail++;
         $display("FAIL frame_done: got %0d pulses want %0d", frame_cnt - f0, fexp);
      end
   endtask

   task automatic test_clear();
      snap_t s;
      int bc;
      drive(10'h001, 1'b0);
      s = sb.pop_front();
      n_chk++;
      if ({row_1, row_2, addr} !== {s.r1, s.r2, s.a}) begin
         n_fail++;
         $display("FAIL clear_state: got %h %h %h want %h %h %h", row_1, row_2, addr, s.r1, s.r2, s.a);
      end
      fork
         begin
            bc = 0;
            while (busy && bc < LONG + 10) begin
               bc++;
               @(negedge clk);
            end
         end
         begin
            idle(3);
            drive(10'h241, 1'b1);
            s = sb.pop_front();
            n_chk++;
            if ({err, row_1, row_2, addr} !== {1'b1, s.r1, s.r2, s.a}) begin
               n_fail++;
               $display("FAIL clear_drop: got err %b %h %h want err 1 %h %h", err, row_1, row_2, s.r1, s.r2);
            end
            idle(1);
            n_chk++;
            if (err !== 1'b0) begin
               n_fail++;
               $display("FAIL clear_err_len: got %b want 0", err);
            end
         end
      join
      n_chk++;
      if (bc != LONG) begin
         n_fail++;
         $display("FAIL clear_busy_len: got %0d want %0d", bc, LONG);
      end
      idle(2);
   endtask

   task automatic test_wrap();
      logic [9:0] seq[7] = '{10'h0A7, 10'h258, 10'h304, 10'h004, 10'h0C0, 10'h25A, 10'h000};
      bit drp[7] = '{0, 0, 1, 0, 0, 0, 0};
      snap_t s;
      for (int i = 0; i < 6; i++) begin
         drive(seq[i], drp[i]);
         s = sb.pop_front();
         n_chk++;
         if ({row_1, row_2, addr, err} !== {s.r1, s.r2, s.a, drp[i]}) begin
            n_fail++;
            $display("FAIL wrap_%0d: got %h %h err %b want %h %h err %b", i, row_2, addr, err, s.r2, s.a, drp[i]);
         end
         idle(EXEC + 1);
      end
      n_chk++;
      if ({row_2[127:120], addr} !== {8'h5A, 7'h27}) begin
         n_fail++;
         $display("FAIL wrap_final: got %h %h want 5a 27", row_2[127:120], addr);
      end
   endtask

   task automatic test_reset_mid();
      snap_t s;
      drive(10'h001, 1'b0);
      s = sb.pop_front();
      idle(10);
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_busy: got %b want 1", busy);
      end
      drive(10'h24D, 1'b1);
      s = sb.pop_front();
      rst = 1'b0;
      #3;
      model_reset();
      s = snap();
      n_chk++;
      if ({row_1, row_2, addr, disp_on, two_line, busy, err} !== {s, 2'b00}) begin
         n_fail++;
         $display("FAIL mid_reset: got %h %b %b want %h 00", {row_1, row_2, addr, disp_on, two_line}, busy, err, s);
      end
      idle(1);
      rst = 1'b1;
      idle(2);
   endtask

   initial begin
      test_reset();
      test_init();
      test_hi();
      test_line2();
      test_clear();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
